// File: rtl/gpu_pixel_write_queue_pkg.sv
// Shared framebuffer geometry, bus widths, colours and queue state encoding
// for the line-drawing GPU.
package gpu_pkg;
    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 400;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 16;

    localparam logic [15:0] COLOR_WHITE = 16'hFFFF;
    localparam logic [15:0] COLOR_BLACK = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } q_state_e;
endpackage

// File: rtl/gpu_pixel_write_queue_if.sv
// Pixel request handshake plus SRAM write-port bundle of the pixel write queue.
// The master side is the producer/observer, the slave side is the queue itself.
interface gpu_pixel_write_queue_if #(
    parameter int ADDR_W = gpu_pkg::ADDR_W,
    parameter int DATA_W = gpu_pkg::DATA_W
);
    logic              I_VIDEO_ON;
    logic              I_PIX_VALID;
    logic [ADDR_W-1:0] I_PIX_ADDR;
    logic [DATA_W-1:0] I_PIX_DATA;
    logic              O_PIX_READY;
    logic              I_CLEAR_REQ;
    logic [DATA_W-1:0] I_CLEAR_COLOR;
    logic [ADDR_W-1:0] O_GPU_ADDR;
    logic [DATA_W-1:0] O_GPU_DATA;
    logic              O_GPU_WRITE;
    logic              O_GPU_READ;
    logic              O_BUSY;
    logic              O_CLEAR_DONE;
    logic              O_ADDR_ERR;

    modport master (
        output I_VIDEO_ON, I_PIX_VALID, I_PIX_ADDR, I_PIX_DATA, I_CLEAR_REQ, I_CLEAR_COLOR,
        input  O_PIX_READY, O_GPU_ADDR, O_GPU_DATA, O_GPU_WRITE, O_GPU_READ,
               O_BUSY, O_CLEAR_DONE, O_ADDR_ERR
    );

    modport slave (
        input  I_VIDEO_ON, I_PIX_VALID, I_PIX_ADDR, I_PIX_DATA, I_CLEAR_REQ, I_CLEAR_COLOR,
        output O_PIX_READY, O_GPU_ADDR, O_GPU_DATA, O_GPU_WRITE, O_GPU_READ,
               O_BUSY, O_CLEAR_DONE, O_ADDR_ERR
    );
endinterface

// File: rtl/gpu_pixel_write_queue_fifo.sv
// Synchronous FIFO holding packed {address, colour} pixel requests.
// Push is ignored when full and pop when empty; no same-cycle bypass.
module gpu_pixel_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 34,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/gpu_pixel_write_queue.sv
// Pixel write queue: buffers drawer writes and issues them to SRAM outside active
// video, with a full-framebuffer clear sweep that preempts (but keeps) queued pixels.
module gpu_pixel_write_queue
    import gpu_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = gpu_pkg::ADDR_W,
    parameter int DATA_W    = gpu_pkg::DATA_W,
    parameter int FB_PIXELS = gpu_pkg::FB_PIXELS
) (
    input logic                    I_CLK,
    input logic                    I_RST,
    gpu_pixel_write_queue_if.slave pif
);
    localparam int                CNT_W    = $clog2(DEPTH) + 1;
    localparam int                WIDTH    = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_PIXELS - 1);

    q_state_e          state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0] clr_color_q, clr_color_d;
    logic [ADDR_W-1:0] gpu_addr_q, gpu_addr_d;
    logic [DATA_W-1:0] gpu_data_q, gpu_data_d;
    logic              gpu_write_q, gpu_write_d;
    logic              clear_done_q, clear_done_d;
    logic              addr_err_q, addr_err_d;
    logic              busy_q, busy_d;

    logic              push, pop, start_clear, clear_last, clearing_d;
    logic [CNT_W-1:0]  fifo_count, cnt_d;
    logic              fifo_empty, fifo_full;
    logic [WIDTH-1:0]  head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign push      = pif.I_PIX_VALID & ~fifo_full;
    assign head_addr = head[WIDTH-1:DATA_W];
    assign head_data = head[DATA_W-1:0];

    gpu_pixel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk_i   (I_CLK),
        .rst_i   (I_RST),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({pif.I_PIX_ADDR, pif.I_PIX_DATA}),
        .rdata_o (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        pop          = 1'b0;
        start_clear  = 1'b0;
        clear_last   = 1'b0;
        clr_addr_d   = clr_addr_q;
        clr_color_d  = clr_color_q;
        gpu_addr_d   = gpu_addr_q;
        gpu_data_d   = gpu_data_q;
        gpu_write_d  = 1'b0;
        clear_done_d = 1'b0;
        addr_err_d   = addr_err_q;

        if (state_q == CLEAR) begin
            if (!pif.I_VIDEO_ON) begin
                gpu_addr_d  = clr_addr_q;
                gpu_data_d  = clr_color_q;
                gpu_write_d = 1'b1;
                if (clr_addr_q == CLR_LAST) begin
                    clear_last   = 1'b1;
                    clear_done_d = 1'b1;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
        end else if (pif.I_CLEAR_REQ) begin
            start_clear = 1'b1;
            clr_addr_d  = '0;
            clr_color_d = pif.I_CLEAR_COLOR;
        end else if (state_q == DRAIN && !fifo_empty && !pif.I_VIDEO_ON) begin
            pop = 1'b1;
            // Out-of-framebuffer entries are dropped silently apart from the sticky flag.
            if (int'(head_addr) < FB_PIXELS) begin
                gpu_addr_d  = head_addr;
                gpu_data_d  = head_data;
                gpu_write_d = 1'b1;
            end else begin
                addr_err_d = 1'b1;
            end
        end

        cnt_d      = fifo_count + CNT_W'(push) - CNT_W'(pop);
        clearing_d = start_clear | ((state_q == CLEAR) & ~clear_last);
        state_d    = clearing_d ? CLEAR : ((cnt_d != '0) ? DRAIN : IDLE);
        busy_d     = clearing_d | (cnt_d != '0);
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q      <= IDLE;
            clr_addr_q   <= '0;
            gpu_addr_q   <= '0;
            gpu_data_q   <= '0;
            gpu_write_q  <= 1'b0;
            clear_done_q <= 1'b0;
            addr_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            gpu_addr_q   <= gpu_addr_d;
            gpu_data_q   <= gpu_data_d;
            gpu_write_q  <= gpu_write_d;
            clear_done_q <= clear_done_d;
            addr_err_q   <= addr_err_d;
            busy_q       <= busy_d;
        end
    end

    always_ff @(posedge I_CLK) begin
        clr_color_q <= clr_color_d;
    end

    assign pif.O_PIX_READY  = ~fifo_full;
    assign pif.O_GPU_ADDR   = gpu_addr_q;
    assign pif.O_GPU_DATA   = gpu_data_q;
    assign pif.O_GPU_WRITE  = gpu_write_q;
    assign pif.O_GPU_READ   = 1'b0;
    assign pif.O_BUSY       = busy_q;
    assign pif.O_CLEAR_DONE = clear_done_q;
    assign pif.O_ADDR_ERR   = addr_err_q;
endmodule

// File: tb/tb_gpu_pixel_write_queue.sv
// Randomised and directed bench for gpu_pixel_write_queue against a queue-based
// transaction model; a reduced framebuffer keeps full clear sweeps short.
module tb_gpu_pixel_write_queue;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int FBP    = 3000;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } pix_t;

    logic clk;
    logic rst;

    gpu_pixel_write_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) pif ();

    gpu_pixel_write_queue #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .FB_PIXELS (FBP)
    ) dut (
        .I_CLK (clk),
        .I_RST (rst),
        .pif   (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state
    pix_t              mq[$];
    bit                m_clearing;
    int                m_caddr;
    logic [DATA_W-1:0] m_ccolor;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    bit                e_write, e_done, e_err, e_busy;

    // Observation counters
    int obs_writes = 0;
    int obs_done   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_clearing = 0;
        m_caddr    = 0;
        m_ccolor   = '0;
        e_addr     = '0;
        e_data     = '0;
        e_write    = 0;
        e_done     = 0;
        e_err      = 0;
        e_busy     = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs present at the edge.
    task automatic model_step();
        bit   ready;
        bit   do_push;
        pix_t p;
        ready   = (mq.size() < DEPTH);
        do_push = pif.I_PIX_VALID && ready;
        e_write = 0;
        e_done  = 0;
        if (m_clearing) begin
            if (!pif.I_VIDEO_ON) begin
                e_write = 1;
                e_addr  = ADDR_W'(m_caddr);
                e_data  = m_ccolor;
                if (m_caddr == FBP - 1) begin
                    e_done     = 1;
                    m_clearing = 0;
                end else begin
                    m_caddr++;
                end
            end
        end else if (pif.I_CLEAR_REQ) begin
            m_clearing = 1;
            m_caddr    = 0;
            m_ccolor   = pif.I_CLEAR_COLOR;
        end else if (mq.size() > 0 && !pif.I_VIDEO_ON) begin
            p = mq.pop_front();
            if (int'(p.a) < FBP) begin
                e_write = 1;
                e_addr  = p.a;
                e_data  = p.d;
            end else begin
                e_err = 1;
            end
        end
        if (do_push) begin
            p.a = pif.I_PIX_ADDR;
            p.d = pif.I_PIX_DATA;
            mq.push_back(p);
        end
        e_busy = m_clearing || (mq.size() != 0);
    endtask

    task automatic compare();
        chk("ready", pif.O_PIX_READY, 64'(mq.size() < DEPTH));
        chk("write", pif.O_GPU_WRITE, 64'(e_write));
        chk("addr", pif.O_GPU_ADDR, 64'(e_addr));
        chk("data", pif.O_GPU_DATA, 64'(e_data));
        chk("done", pif.O_CLEAR_DONE, 64'(e_done));
        chk("addr_err", pif.O_ADDR_ERR, 64'(e_err));
        chk("busy", pif.O_BUSY, 64'(e_busy));
        chk("read", pif.O_GPU_READ, 64'(0));
        if (pif.O_GPU_WRITE === 1'b1) obs_writes++;
        if (pif.O_CLEAR_DONE === 1'b1) begin
            obs_done++;
            chk("done_addr", pif.O_GPU_ADDR, 64'(FBP - 1));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic drv(input bit v, input int a, input int d);
        pif.I_PIX_VALID = v;
        pif.I_PIX_ADDR  = ADDR_W'(a);
        pif.I_PIX_DATA  = DATA_W'(d);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"}, pif.O_GPU_ADDR, 64'(0));
        chk({tag, "_data"}, pif.O_GPU_DATA, 64'(0));
        chk({tag, "_write"}, pif.O_GPU_WRITE, 64'(0));
        chk({tag, "_read"}, pif.O_GPU_READ, 64'(0));
        chk({tag, "_busy"}, pif.O_BUSY, 64'(0));
        chk({tag, "_done"}, pif.O_CLEAR_DONE, 64'(0));
        chk({tag, "_err"}, pif.O_ADDR_ERR, 64'(0));
        chk({tag, "_ready"}, pif.O_PIX_READY, 64'(1));
    endtask

    // Runs until the model finishes its clear sweep; returns 1 if it did in budget.
    task automatic run_until_done(input int budget, input int pause_at, output bit seen);
        int start_done;
        start_done = obs_done;
        seen = 0;
        for (int k = 0; k < budget; k++) begin
            if (pause_at >= 0 && k == pause_at) pif.I_VIDEO_ON = 1'b1;
            if (pause_at >= 0 && k == pause_at + 100) pif.I_VIDEO_ON = 1'b0;
            cycle();
            if (obs_done != start_done) begin
                seen = 1;
                break;
            end
        end
    endtask

    initial begin
        bit seen;
        int w0, d0;
        rst = 1'b1;
        pif.I_VIDEO_ON    = 1'b0;
        pif.I_CLEAR_REQ   = 1'b0;
        pif.I_CLEAR_COLOR = '0;
        drv(0, 0, 0);
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Three consecutive pixels, written back-to-back one cycle behind the pushes
        drv(1, 10, 16'hFFFF); cycle();
        chk("t1_first_nowrite", pif.O_GPU_WRITE, 64'(0));
        drv(1, 11, 16'h0F0F); cycle();
        chk("t1_a0", {pif.O_GPU_WRITE, pif.O_GPU_ADDR, pif.O_GPU_DATA}, {1'b1, 18'd10, 16'hFFFF});
        drv(1, 651, 16'h0000); cycle();
        chk("t1_a1", {pif.O_GPU_WRITE, pif.O_GPU_ADDR, pif.O_GPU_DATA}, {1'b1, 18'd11, 16'h0F0F});
        drv(0, 0, 0); cycle();
        chk("t1_a2", {pif.O_GPU_WRITE, pif.O_GPU_ADDR, pif.O_GPU_DATA}, {1'b1, 18'd651, 16'h0000});
        cycle();
        chk("t1_idle_write", pif.O_GPU_WRITE, 64'(0));
        chk("t1_idle_busy", pif.O_BUSY, 64'(0));

        // Fill during active video: 16 accepted, the 17th is held off
        pif.I_VIDEO_ON = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drv(1, 100 + i, 16'h1000 + i);
            cycle();
            if (i == 15) chk("t2_ready_full", pif.O_PIX_READY, 64'(0));
        end
        chk("t2_no_write", pif.O_GPU_WRITE, 64'(0));
        chk("t2_busy", pif.O_BUSY, 64'(1));
        drv(0, 0, 0);
        pif.I_VIDEO_ON = 1'b0;
        cycle();
        chk("t2_first", {pif.O_GPU_WRITE, pif.O_GPU_ADDR}, {1'b1, 18'd100});
        chk("t2_ready_back", pif.O_PIX_READY, 64'(1));
        obs_writes = 1;
        for (int i = 0; i < 17; i++) cycle();
        chk("t2_write_count", obs_writes, 64'(16));

        // Full clear with a video pause in the middle of the sweep
        pif.I_CLEAR_REQ = 1'b1; pif.I_CLEAR_COLOR = 16'h0000;
        cycle();
        pif.I_CLEAR_REQ = 1'b0;
        obs_writes = 0;
        run_until_done(FBP + 400, 1500, seen);
        chk("t3_done_seen", 64'(seen), 64'(1));
        chk("t3_writes", obs_writes, 64'(FBP));
        chk("t3_done_count", obs_done, 64'(1));
        cycle();
        chk("t3_done_single", pif.O_CLEAR_DONE, 64'(0));
        chk("t3_idle", pif.O_BUSY, 64'(0));

        // Out-of-range address is dropped and flags the sticky error
        drv(1, FBP, 16'h1234); cycle();
        drv(1, 5, 16'hABCD); cycle();
        chk("t4_bad_nowrite", pif.O_GPU_WRITE, 64'(0));
        chk("t4_err_set", pif.O_ADDR_ERR, 64'(1));
        drv(0, 0, 0); cycle();
        chk("t4_good", {pif.O_GPU_WRITE, pif.O_GPU_ADDR, pif.O_GPU_DATA}, {1'b1, 18'd5, 16'hABCD});
        cycle(); cycle();
        chk("t4_err_sticky", pif.O_ADDR_ERR, 64'(1));

        // Clear preempts queued pixels, which are written after the sweep
        pif.I_VIDEO_ON = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drv(1, 200 + i, 16'h0A00 + i);
            cycle();
        end
        drv(0, 0, 0);
        pif.I_CLEAR_REQ = 1'b1; pif.I_CLEAR_COLOR = 16'hFFFF;
        cycle();
        pif.I_CLEAR_REQ = 1'b0;
        cycle(); cycle();
        pif.I_VIDEO_ON = 1'b0;
        run_until_done(FBP + 100, -1, seen);
        chk("t5_done_seen", 64'(seen), 64'(1));
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t5_pix", {pif.O_GPU_WRITE, pif.O_GPU_ADDR, pif.O_GPU_DATA},
                {1'b1, 18'(200 + i), 16'(16'h0A00 + i)});
        end

        // Asynchronous reset in the middle of a sweep
        pif.I_CLEAR_REQ = 1'b1; pif.I_CLEAR_COLOR = 16'h1234;
        cycle();
        pif.I_CLEAR_REQ = 1'b0;
        seen = 0;
        for (int k = 0; k < 1200; k++) begin
            drv(k < 2, 300 + k, 16'h5555);
            cycle();
            if (pif.O_GPU_WRITE === 1'b1 && pif.O_GPU_ADDR === 18'd1000) begin
                seen = 1;
                break;
            end
        end
        chk("t6_reached_1000", 64'(seen), 64'(1));
        drv(0, 0, 0);
        d0 = obs_done;
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) cycle();
        chk("t6_no_done", obs_done, 64'(d0));
        chk("t6_ready", pif.O_PIX_READY, 64'(1));
        chk("t6_busy", pif.O_BUSY, 64'(0));

        // Randomised traffic with backpressure, bad addresses and occasional clears
        w0 = obs_writes;
        for (int k = 0; k < 4000; k++) begin
            pif.I_VIDEO_ON  = ($urandom_range(0, 2) == 0);
            pif.I_CLEAR_REQ = ($urandom_range(0, 1499) == 0);
            pif.I_CLEAR_COLOR = 16'($urandom);
            if ($urandom_range(0, 15) == 0)
                drv($urandom_range(0, 3) != 0, FBP + $urandom_range(0, 200), $urandom);
            else
                drv($urandom_range(0, 3) != 0, $urandom_range(0, FBP - 1), $urandom);
            cycle();
        end
        drv(0, 0, 0);
        pif.I_VIDEO_ON  = 1'b0;
        pif.I_CLEAR_REQ = 1'b0;
        for (int k = 0; k < FBP + 100; k++) begin
            if (!m_clearing && mq.size() == 0) break;
            cycle();
        end
        cycle();
        chk("t7_drained_busy", pif.O_BUSY, 64'(0));
        chk("t7_some_writes", 64'(obs_writes > w0), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gpu_pixel_write_queue.md
Name: gpu_pixel_write_queue

Overview:
Downstream stage of the line-drawing GPU. It accepts pixel-write requests (framebuffer address plus colour) through a valid/ready handshake and buffers them in a FIFO. It drives the SRAM write port only while I_VIDEO_ON is low, because scanout owns SRAM during active video. It also provides a hardware full-screen clear, which replaces the drawer's old count[25]-based screen reset.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
ADDR_W, 18, SRAM word-address width
DATA_W, 16, pixel colour width (4x4-bit)
FB_PIXELS, 256000, valid framebuffer addresses (640x400)

Ports:
I_CLK  in  1  clock; all state updates on its rising edge
I_RST  in  1  asynchronous, active-high reset
I_VIDEO_ON  in  1  high = scanout owns SRAM; no writes issued
I_PIX_VALID  in  1  pixel request valid
I_PIX_ADDR  in  ADDR_W  pixel address (row*640+col)
I_PIX_DATA  in  DATA_W  pixel colour
O_PIX_READY  out  1  FIFO can accept a request
I_CLEAR_REQ  in  1  start full-framebuffer clear (level, sampled)
I_CLEAR_COLOR  in  DATA_W  clear colour, latched when the request is taken
O_GPU_ADDR  out  ADDR_W  SRAM address
O_GPU_DATA  out  DATA_W  SRAM write data
O_GPU_WRITE  out  1  SRAM write strobe
O_GPU_READ  out  1  SRAM read strobe, held 0
O_BUSY  out  1  clear in progress or FIFO non-empty
O_CLEAR_DONE  out  1  one-cycle pulse on the last clear write
O_ADDR_ERR  out  1  sticky: a popped pixel had an address >= FB_PIXELS

Behaviour:
- Reset (async, while I_RST=1): FIFO empty, state IDLE, clear counter 0. O_GPU_ADDR, O_GPU_DATA, O_GPU_WRITE, O_GPU_READ, O_BUSY, O_CLEAR_DONE and O_ADDR_ERR are all 0. O_PIX_READY is 1. Any clear in progress is aborted with no done pulse.
- Handshake:
  - O_PIX_READY = (count < DEPTH), decoded from the registered count.
  - A push happens on an edge where I_PIX_VALID & O_PIX_READY.
  - A request with valid high and ready low is not accepted. The producer holds it.
  - There is no same-cycle bypass. At full, a pop does not allow a push in the same cycle.
  - Pushes are accepted in every state, and regardless of I_VIDEO_ON.
- States:
  - IDLE: FIFO empty and no clear.
  - DRAIN: FIFO non-empty.
  - CLEAR: sweep in progress.
  - I_CLEAR_REQ=1 in IDLE or DRAIN moves to CLEAR on the next edge, latching I_CLEAR_COLOR and setting the clear address to 0.
  - I_CLEAR_REQ while in CLEAR is ignored.
  - CLEAR preempts DRAIN. Queued pixels stay in the FIFO and are written after the clear, so they survive it.
- Write issue (registered outputs): on each edge where I_VIDEO_ON=0, at most one write is issued.
  - In CLEAR: O_GPU_ADDR = clear address, O_GPU_DATA = latched colour, O_GPU_WRITE=1, then the clear address increments.
  - In DRAIN: pop the head entry, drive its address and data, O_GPU_WRITE=1.
  - Latency: a pixel pushed into an empty FIFO at edge N appears on the outputs after edge N+1, provided I_VIDEO_ON=0 and no clear is active.
- No-write cycles: O_GPU_WRITE=0, and O_GPU_ADDR and O_GPU_DATA hold their values. This applies when I_VIDEO_ON=1, the FIFO is empty, or the state is IDLE.
- I_VIDEO_ON=1 pauses both the clear sweep and draining. No address is skipped or repeated on resume.
- Clear end:
  - The write to address FB_PIXELS-1 is issued with O_CLEAR_DONE=1 in that same output cycle.
  - Next state is DRAIN if the FIFO is non-empty, otherwise IDLE.
  - The clear counter is ADDR_W bits; the sweep ends at FB_PIXELS-1 and never wraps.
- Bad address: a popped entry with address >= FB_PIXELS is consumed with no write (O_GPU_WRITE=0 that cycle), and O_ADDR_ERR is set until reset.
- O_BUSY = (state==CLEAR) | (count != 0), registered.

Decomposition:
- Shared package gpu_pkg:
  - FB_WIDTH=640, FB_HEIGHT=400, FB_PIXELS=256000
  - ADDR_W=18, DATA_W=16
  - COLOR_WHITE=16'hFFFF, COLOR_BLACK=16'h0000
  - queue state enum {IDLE, DRAIN, CLEAR}
- One sub-module: gpu_pixel_fifo, a synchronous FIFO with DEPTH and width ADDR_W+DATA_W, exposing push, pop, count, empty and full. All arbitration and the clear sweep stay in the top level.

Test Plan:
- Reset, then I_VIDEO_ON=0 and push (10,FFFF), (11,0F0F), (651,0000) on consecutive cycles -> three consecutive writes with matching address/data in order, first one cycle after the first push, then O_GPU_WRITE=0 and O_BUSY=0.
- I_VIDEO_ON=1, push 17 requests -> O_PIX_READY falls after the 16th, 17th not accepted, no writes. Drop I_VIDEO_ON -> 16 ordered writes, and O_PIX_READY rises after the first pop.
- I_CLEAR_REQ with colour 0000, I_VIDEO_ON=0, toggle I_VIDEO_ON high for 100 cycles mid-sweep -> exactly 256000 writes covering addresses 0..255999 once each, and a single O_CLEAR_DONE coincident with address 255999.
- Push address 256000 then address 5 -> no write for the first, O_ADDR_ERR=1 and stays 1, address 5 written normally.
- Queue 4 pixels with I_VIDEO_ON=1, then assert I_CLEAR_REQ, then drop I_VIDEO_ON -> full clear sweep first, then the 4 pixels written after O_CLEAR_DONE.
- Assert I_RST mid-clear at address 1000 -> all outputs go to reset values without waiting for an edge, no O_CLEAR_DONE, FIFO empty, O_PIX_READY=1 after release.
